sat_bin_unloader: RTL and testbench

- Read-side counterpart of the external bin-load port of sat_bin: after a solve, it reads back the clause-bin, var-bin, var-state and lvl-state BRAMs through the `*_ex` port set.
- Streams every word out as a typed record on a valid/ready interface.
- Sits between sat_bin and the host/bin-store path that writes updated bins (bin_updated, value/implied/level, dcd_bin/has_bkt) back to global memory.

---
 rtl/sat_bin_pkg.sv | 37 +++
 rtl/sat_bin_unloader.sv | 180 ++++++++++++++++++
 tb/tb_sat_bin_unloader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sat_bin_pkg.sv
// sat_bin_pkg
//   Shared types and helpers for the sat_bin bin-unload path.
//   - rec_type_t     : record type tag streamed with every unloaded word
//                      (also used as the phase of the unloader).
//   - unload_state_t : unloader FSM states.
//   - bin_limit()    : number of words to read for a given bin count, clamped
//                      to the highest address the RAM port can reach.
package sat_bin_pkg;

    typedef enum logic [1:0] {
        REC_CLAUSE = 2'd0,
        REC_VAR    = 2'd1,
        REC_VS     = 2'd2,
        REC_LS     = 2'd3
    } rec_type_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRESENT = 3'd3,
        ST_FINISH  = 3'd4
    } unload_state_t;

    // Full-width product nb*per_bin, clamped to 2^addr_width-1. Address 0 is
    // reserved, so the last readable word sits at the clamp value itself.
    function automatic logic [31:0] bin_limit(input logic [31:0] nb,
                                              input logic [31:0] per_bin,
                                              input int          addr_width);
        logic [63:0] prod;
        logic [63:0] cap;
        prod = {32'd0, nb} * {32'd0, per_bin};
        cap  = (64'd1 << addr_width) - 64'd1;
        return (prod > cap) ? cap[31:0] : prod[31:0];
    endfunction

endpackage

// File: rtl/sat_bin_unloader.sv
// sat_bin_unloader
//   Reads back the clause, var, var-state and lvl-state BRAMs of sat_bin
//   through the external (*_ex) port set after a solve, and streams every word
//   as a typed record on a valid/ready interface.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     start_i, nb_i       start pulse and bin count (sampled in IDLE only)
//     busy_o, done_o      busy from the cycle after start through done; done pulse
//     apply_ex_o          external RAM port ownership (mirrors busy_o)
//     ram_addr_*_ex_o     registered read addresses, 0 unless that RAM is active
//     ram_dout_*_ex_i     read data, valid one cycle after the address
//     out_valid_o/out_ready_i, out_type_o/out_addr_o/out_data_o
//                         record stream; data zero-extended to WIDTH_OUT
//
//   Each record takes ISSUE (address out) -> CAPTURE (dout back) -> PRESENT
//   (hold until handshake), so the stream runs at one record per 3 cycles.
module sat_bin_unloader
    import sat_bin_pkg::*;
#(
    parameter int NUM_CLAUSES_A_BIN = 8,
    parameter int NUM_VARS_A_BIN    = 8,
    parameter int WIDTH_CLAUSES     = 16,
    parameter int WIDTH_VAR         = 12,
    parameter int WIDTH_VAR_STATES  = 19,
    parameter int WIDTH_LVL_STATES  = 11,
    parameter int ADDR_WIDTH        = 9,
    parameter int WIDTH_OUT         = 19
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [WIDTH_CLAUSES-1:0]    nb_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        apply_ex_o,
    output logic [ADDR_WIDTH-1:0]       ram_addr_c_ex_o,
    input  logic [WIDTH_CLAUSES-1:0]    ram_dout_c_ex_i,
    output logic [ADDR_WIDTH-1:0]       ram_addr_v_ex_o,
    input  logic [WIDTH_VAR-1:0]        ram_dout_v_ex_i,
    output logic [ADDR_WIDTH-1:0]       ram_addr_vs_ex_o,
    input  logic [WIDTH_VAR_STATES-1:0] ram_dout_vs_ex_i,
    output logic [ADDR_WIDTH-1:0]       ram_addr_ls_ex_o,
    input  logic [WIDTH_LVL_STATES-1:0] ram_dout_ls_ex_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [1:0]                  out_type_o,
    output logic [ADDR_WIDTH-1:0]       out_addr_o,
    output logic [WIDTH_OUT-1:0]        out_data_o
);

    unload_state_t           state_reg, state_next;
    rec_type_t               phase_reg, phase_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [31:0]             nc_reg, nc_next;
    logic [31:0]             nv_reg, nv_next;
    logic [31:0]             cur_limit;
    rec_type_t               out_type_reg, out_type_next;
    logic [ADDR_WIDTH-1:0]   out_addr_reg, out_addr_next;
    logic [WIDTH_OUT-1:0]    out_data_reg, out_data_next;
    logic [ADDR_WIDTH-1:0]   addr_c_reg, addr_v_reg, addr_vs_reg, addr_ls_reg;
    logic                    drive_addr;

    assign cur_limit = (phase_reg == REC_CLAUSE) ? nc_reg : nv_reg;

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        addr_next     = addr_reg;
        nc_next       = nc_reg;
        nv_next       = nv_reg;
        out_type_next = out_type_reg;
        out_addr_next = out_addr_reg;
        out_data_next = out_data_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    nc_next = bin_limit(32'(nb_i), 32'(NUM_CLAUSES_A_BIN), ADDR_WIDTH);
                    nv_next = bin_limit(32'(nb_i), 32'(NUM_VARS_A_BIN), ADDR_WIDTH);
                    if (nb_i == '0) begin
                        state_next = ST_FINISH;
                    end else begin
                        phase_next = REC_CLAUSE;
                        addr_next  = ADDR_WIDTH'(1);
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                out_type_next = phase_reg;
                out_addr_next = addr_reg;
                out_data_next = '0;
                case (phase_reg)
                    REC_CLAUSE: out_data_next[WIDTH_CLAUSES-1:0]    = ram_dout_c_ex_i;
                    REC_VAR:    out_data_next[WIDTH_VAR-1:0]        = ram_dout_v_ex_i;
                    REC_VS:     out_data_next[WIDTH_VAR_STATES-1:0] = ram_dout_vs_ex_i;
                    default:    out_data_next[WIDTH_LVL_STATES-1:0] = ram_dout_ls_ex_i;
                endcase
                state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_ready_i) begin
                    // The counter walks 1..limit, so equality marks the phase end.
                    if (32'(addr_reg) != cur_limit) begin
                        addr_next  = addr_reg + ADDR_WIDTH'(1);
                        state_next = ST_ISSUE;
                    end else if (phase_reg != REC_LS) begin
                        case (phase_reg)
                            REC_CLAUSE: phase_next = REC_VAR;
                            REC_VAR:    phase_next = REC_VS;
                            default:    phase_next = REC_LS;
                        endcase
                        addr_next  = ADDR_WIDTH'(1);
                        state_next = ST_ISSUE;
                    end else begin
                        state_next = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address ports are registered from the next-state values so they change
    // together with the FSM and never glitch through the phase decode.
    assign drive_addr = (state_next == ST_ISSUE) || (state_next == ST_CAPTURE) ||
                        (state_next == ST_PRESENT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            phase_reg    <= REC_CLAUSE;
            addr_reg     <= '0;
            nc_reg       <= '0;
            nv_reg       <= '0;
            out_type_reg <= REC_CLAUSE;
            out_addr_reg <= '0;
            out_data_reg <= '0;
            addr_c_reg   <= '0;
            addr_v_reg   <= '0;
            addr_vs_reg  <= '0;
            addr_ls_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            addr_reg     <= addr_next;
            nc_reg       <= nc_next;
            nv_reg       <= nv_next;
            out_type_reg <= out_type_next;
            out_addr_reg <= out_addr_next;
            out_data_reg <= out_data_next;
            addr_c_reg   <= (drive_addr && phase_next == REC_CLAUSE) ? addr_next : '0;
            addr_v_reg   <= (drive_addr && phase_next == REC_VAR)    ? addr_next : '0;
            addr_vs_reg  <= (drive_addr && phase_next == REC_VS)     ? addr_next : '0;
            addr_ls_reg  <= (drive_addr && phase_next == REC_LS)     ? addr_next : '0;
        end
    end

    assign busy_o           = (state_reg != ST_IDLE);
    assign apply_ex_o       = busy_o;
    assign done_o           = (state_reg == ST_FINISH);
    assign out_valid_o      = (state_reg == ST_PRESENT);
    assign out_type_o       = out_type_reg;
    assign out_addr_o       = out_addr_reg;
    assign out_data_o       = out_data_reg;
    assign ram_addr_c_ex_o  = addr_c_reg;
    assign ram_addr_v_ex_o  = addr_v_reg;
    assign ram_addr_vs_ex_o = addr_vs_reg;
    assign ram_addr_ls_ex_o = addr_ls_reg;

endmodule

// File: tb/tb_sat_bin_unloader.sv
// tb_sat_bin_unloader
//   Job table of {bin count, ready rate, restart pokes, abort point} with the
//   expected record count and last clause address, run against RAM models
//   filled with random data and a reference record list built from the
//   unload order (all clause words, then var, var-state, lvl-state).
module tb_sat_bin_unloader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] nb_i;
    logic        busy, done, apply_ex;
    logic [8:0]  addr_c, addr_v, addr_vs, addr_ls;
    logic [15:0] dout_c;
    logic [11:0] dout_v;
    logic [18:0] dout_vs;
    logic [10:0] dout_ls;
    logic        out_valid, out_ready;
    logic [1:0]  out_type;
    logic [8:0]  out_addr;
    logic [18:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sat_bin_unloader dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start),
        .nb_i             (nb_i),
        .busy_o           (busy),
        .done_o           (done),
        .apply_ex_o       (apply_ex),
        .ram_addr_c_ex_o  (addr_c),
        .ram_dout_c_ex_i  (dout_c),
        .ram_addr_v_ex_o  (addr_v),
        .ram_dout_v_ex_i  (dout_v),
        .ram_addr_vs_ex_o (addr_vs),
        .ram_dout_vs_ex_i (dout_vs),
        .ram_addr_ls_ex_o (addr_ls),
        .ram_dout_ls_ex_i (dout_ls),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_type_o       (out_type),
        .out_addr_o       (out_addr),
        .out_data_o       (out_data)
    );

    // RAM models with one-cycle registered read
    logic [15:0] mem_c  [512];
    logic [11:0] mem_v  [512];
    logic [18:0] mem_vs [512];
    logic [10:0] mem_ls [512];

    always @(posedge clk) begin
        dout_c  <= mem_c[addr_c];
        dout_v  <= mem_v[addr_v];
        dout_vs <= mem_vs[addr_vs];
        dout_ls <= mem_ls[addr_ls];
    end

    typedef struct {
        logic [1:0]  t;
        int          a;
        logic [18:0] d;
    } rec_t;

    typedef struct {
        int nb;
        int pct;
        bit poke;
        int abort_at;
        int exp_cnt;
        int exp_last_c;
    } job_t;

    rec_t exp_q[$];
    job_t jobs[7];

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] pack_rec(input rec_t r);
        logic [8:0] a9;
        a9 = 9'(r.a);
        return {34'd0, r.t, a9, r.d};
    endfunction

    function automatic logic [63:0] cur_rec();
        return {34'd0, out_type, out_addr, out_data};
    endfunction

    function automatic logic [63:0] all_outs();
        return {10'd0, busy, done, apply_ex, out_valid, addr_c, addr_v, addr_vs, addr_ls,
                out_type, out_addr, out_data};
    endfunction

    task automatic run_job(input int j);
        int nb, pct, lim_c, lim_v, lim, got, cyc, last_hs, done_cyc, max_c, budget;
        bit done_seen, aborted, inv_ok, gap_ok, stall;
        logic [63:0] held, cur;
        int nz;
        rec_t r;
        nb  = jobs[j].nb;
        pct = jobs[j].pct;
        lim_c = nb * 8;
        if (lim_c > 511) lim_c = 511;
        lim_v = nb * 8;
        if (lim_v > 511) lim_v = 511;
        exp_q.delete();
        for (int t = 0; t < 4; t++) begin
            lim = (t == 0) ? lim_c : lim_v;
            for (int a = 1; a <= lim; a++) begin
                r.t = 2'(t);
                r.a = a;
                case (t)
                    0: r.d = 19'(mem_c[a]);
                    1: r.d = 19'(mem_v[a]);
                    2: r.d = 19'(mem_vs[a]);
                    default: r.d = 19'(mem_ls[a]);
                endcase
                exp_q.push_back(r);
            end
        end

        start = 1'b1;
        nb_i  = 16'(nb);
        @(posedge clk); #1;
        start = 1'b0;

        cyc = 0; last_hs = -1; done_cyc = -1; got = 0; max_c = 0;
        inv_ok = 1'b1; gap_ok = 1'b1; stall = 1'b0; done_seen = 1'b0; aborted = 1'b0;
        held = '0;
        budget = 50 + 40 * (lim_c + 3 * lim_v);
        while (!done_seen && !aborted && cyc < budget) begin
            out_ready = ($urandom_range(0, 99) < pct);
            if (jobs[j].poke && (cyc % 5 == 2)) begin
                start = 1'b1;
                nb_i  = 16'($urandom_range(1, 3));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cur = cur_rec();
            if (!(busy && apply_ex)) inv_ok = 1'b0;
            nz = int'(addr_c != 0) + int'(addr_v != 0) + int'(addr_vs != 0) + int'(addr_ls != 0);
            if (nz > 1) inv_ok = 1'b0;
            if (stall) chk(out_valid && cur == held, $sformatf("job%0d_stall_hold", j),
                           {cur[62:0], out_valid}, {held[62:0], 1'b1});
            stall = out_valid && !out_ready;
            if (stall) held = cur;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, $sformatf("job%0d_extra_record", j), cur, 64'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk(cur == pack_rec(r), $sformatf("job%0d_record%0d", j, got), cur, pack_rec(r));
                end
                if (pct == 100 && last_hs >= 0 && cyc - last_hs != 3) gap_ok = 1'b0;
                last_hs = cyc;
                got++;
                if (out_type == 2'd0 && int'(out_addr) > max_c) max_c = int'(out_addr);
                if (jobs[j].abort_at > 0 && got == jobs[j].abort_at) aborted = 1'b1;
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;

        chk(got == jobs[j].exp_cnt, $sformatf("job%0d_count", j), 64'(got), 64'(jobs[j].exp_cnt));
        chk(max_c == jobs[j].exp_last_c, $sformatf("job%0d_last_clause", j), 64'(max_c), 64'(jobs[j].exp_last_c));
        chk(inv_ok, $sformatf("job%0d_busy_apply_addr", j), 64'(inv_ok), 64'd1);
        if (pct == 100 && got > 1)
            chk(gap_ok, $sformatf("job%0d_rate", j), 64'(gap_ok), 64'd1);

        if (aborted) begin
            // reset mid-run, with a coincident start that must lose to reset
            rst = 1'b1; start = 1'b1; nb_i = 16'd1;
            @(posedge clk); #1;
            rst = 1'b0; start = 1'b0;
            @(negedge clk);
            chk(all_outs() == 64'd0, $sformatf("job%0d_reset_outputs", j), all_outs(), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk(!busy && !done, $sformatf("job%0d_reset_stays_idle", j), {62'd0, busy, done}, 64'd0);
            @(posedge clk); #1;
        end else if (!done_seen) begin
            chk(1'b0, $sformatf("job%0d_timeout", j), 64'(cyc), 64'(budget));
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        end else begin
            chk(exp_q.size() == 0, $sformatf("job%0d_missing_records", j), 64'(exp_q.size()), 64'd0);
            chk(done_cyc - last_hs == 1, $sformatf("job%0d_done_latency", j),
                64'(done_cyc - last_hs), 64'd1);
            @(negedge clk);
            chk(!busy && !apply_ex && !done && !out_valid, $sformatf("job%0d_idle_after_done", j),
                {60'd0, busy, apply_ex, done, out_valid}, 64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        jobs[0] = '{nb: 1,   pct: 100, poke: 1'b0, abort_at: 0,  exp_cnt: 32,   exp_last_c: 8};
        jobs[1] = '{nb: 2,   pct: 100, poke: 1'b0, abort_at: 0,  exp_cnt: 64,   exp_last_c: 16};
        jobs[2] = '{nb: 1,   pct: 30,  poke: 1'b0, abort_at: 0,  exp_cnt: 32,   exp_last_c: 8};
        jobs[3] = '{nb: 0,   pct: 100, poke: 1'b0, abort_at: 0,  exp_cnt: 0,    exp_last_c: 0};
        jobs[4] = '{nb: 2,   pct: 100, poke: 1'b0, abort_at: 20, exp_cnt: 20,   exp_last_c: 16};
        jobs[5] = '{nb: 1,   pct: 100, poke: 1'b0, abort_at: 0,  exp_cnt: 32,   exp_last_c: 8};
        jobs[6] = '{nb: 100, pct: 100, poke: 1'b1, abort_at: 0,  exp_cnt: 2044, exp_last_c: 511};

        for (int i = 0; i < 512; i++) begin
            mem_c[i]  = 16'($urandom);
            mem_v[i]  = 12'($urandom);
            mem_vs[i] = 19'($urandom);
            mem_ls[i] = 11'($urandom);
        end

        rst = 1'b1; start = 1'b0; nb_i = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(all_outs() == 64'd0, "reset_state", all_outs(), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int j = 0; j < 7; j++) run_job(j);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
